exponent_unit: RTL and testbench
================================

Name: exponent_unit

Overview:
Parametrised iterative integer exponentiation engine computing base^exponent with right-to-left square-and-multiply.
It is the compute core behind the board-level exponent accelerator. The board wrapper / memory-mapped glue drives start and operands from switches or registers, and shows result/overflow on HEX/LEDR.
Generalises the fixed-width design with configurable operand widths, a wrap/saturate mode, overflow detection and a start/busy/done handshake.

Parameters:
WIDTH, 32, base and result width in bits (>= 2)
EXP_WIDTH, 8, exponent width in bits (>= 1)
SATURATE, 0, 0 = result wraps modulo 2^WIDTH on overflow; 1 = result clamps to all-ones on overflow

Ports:
clk_clk  input  1  system clock (50 MHz on board)
reset_reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
base  input  WIDTH  unsigned base, latched on accepted start
exponent  input  EXP_WIDTH  unsigned exponent, latched on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: result/overflow valid
result  output  WIDTH  final value; held until next accepted start
overflow  output  1  true result >= 2^WIDTH; held with result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports named clk_clk and reset_reset_n.
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, result=0, overflow=0, internal registers cleared. No partial result survives.
- States:
  - IDLE: start=1 at edge N latches base->b_reg, exponent->e_reg, acc=1, b_ovf=0, ovf_reg=0, then goes to RUN.
  - RUN: one exponent bit per cycle.
    - If e_reg[0]=1: acc <= low WIDTH bits of acc*b_reg. ovf_reg sets if upper WIDTH bits of that product != 0, or if b_ovf=1.
    - Always: b_reg <= low bits of b_reg*b_reg; b_ovf sets if the square's upper half != 0. e_reg <= e_reg>>1.
    - If e_reg>>1 == 0, go to DONE at that same edge; result/overflow load from the updated acc/ovf_reg (saturated to all-ones if SATURATE=1 and overflow).
  - DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Latency: m = max(1, bitlength(exponent)) RUN cycles. Start accepted at edge N gives done high in the cycle after edge N+m. For EXP_WIDTH=8, maximum is 8 RUN cycles.
- b_ovf matters only if a later set bit uses b_reg. A squared base that overflows but is never multiplied does not set overflow.
- Wrapped result is exact modulo 2^WIDTH even when overflow=1.
- base=0 or 1 never overflows. exponent=0 gives result=1 for any base, including 0^0=1.
- start during RUN or DONE is ignored; operand changes while busy are ignored.
- result/overflow change only at the DONE-entry edge or at reset. Between operations they hold the last value.
- Multipliers: two WIDTH x WIDTH -> 2*WIDTH unsigned, combinational within one cycle. Pipelining is out of scope.

Decomposition:
- Package exponent_pkg: state enum (IDLE, RUN, DONE) and default width constants.
- Sub-module exponent_mul_step (purely combinational), instantiated twice (multiply and square):
  - inputs: a, b, in_ovf
  - outputs: low-half product, ovf_out = in_ovf | (upper half != 0)
- The FSM, registers and saturation mux stay in exponent_unit.

Test Plan:
- WIDTH=32, SATURATE=0: base=3, exponent=5 -> done after 3 RUN cycles; result=243, overflow=0; busy high 4 cycles; done pulse exactly 1 cycle.
- exponent=0 with base=7, then with base=0 -> result=1, overflow=0, m=1 (done in the 2nd cycle after start edge).
- base=2, exponent=31 -> 0x80000000, overflow=0. base=2, exponent=32 -> result=0, overflow=1. Repeat with SATURATE=1 -> result=0xFFFFFFFF, overflow=1.
- base=65536, exponent=1 -> result=65536, overflow=0 (unused squared base overflows). base=65536, exponent=2 -> overflow=1, result=0 (wrap).
- start pulsed again with new operands during RUN and during DONE -> ignored; first result (3^5=243) delivered unchanged. Next start in IDLE is accepted.
- Assert reset_reset_n low mid-RUN (base=3, exponent=200) -> busy/done/result/overflow go to 0 immediately (asynchronous). After release, IDLE; a fresh 3^4 gives 81.

Source files
------------

// File: rtl/exponent_pkg.sv
// Shared types and default sizes for the exponent engine.
package exponent_pkg;

    // Controller states: wait for a request, iterate over exponent bits, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_EXP_WIDTH = 8;

endpackage : exponent_pkg

// File: rtl/exponent_unit_if.sv
// Request/response bundle between the board glue (master) and the engine (slave).
interface exponent_unit_if #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 overflow;

    modport master (
        output start, base, exponent,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, base, exponent,
        output busy, done, result, overflow
    );
endinterface : exponent_unit_if

// File: rtl/exponent_mul_step.sv
// One WIDTH x WIDTH multiply: keeps the low half and flags any significant upper half.
module exponent_mul_step
    import exponent_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_ovf,
    output logic [WIDTH-1:0] prod_lo,
    output logic             ovf_out
);
    logic [2*WIDTH-1:0] prod;

    assign prod    = a * b;
    assign prod_lo = prod[WIDTH-1:0];
    // Overflow is sticky through the chain: an operand that already lost bits taints the product.
    assign ovf_out = in_ovf | (prod[2*WIDTH-1:WIDTH] != '0);
endmodule : exponent_mul_step

// File: rtl/exponent_unit.sv
// Iterative base^exponent engine using right-to-left square-and-multiply, one exponent bit per cycle.
module exponent_unit
    import exponent_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter bit SATURATE  = 1'b0
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    exponent_unit_if.slave  bus
);
    state_t               state_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     acc_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic                 b_ovf_q;
    logic                 ovf_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     result_q;
    logic                 overflow_q;

    logic [WIDTH-1:0]     mul_lo;
    logic                 mul_ovf;
    logic [WIDTH-1:0]     sq_lo;
    logic                 sq_ovf;
    logic [WIDTH-1:0]     acc_d;
    logic                 ovf_d;
    logic [EXP_WIDTH-1:0] e_d;
    logic                 last_bit;
    logic [WIDTH-1:0]     result_d;

    // acc * b: the squared base is only trusted if it has not already overflowed.
    exponent_mul_step #(.WIDTH(WIDTH)) u_mul (
        .a       (acc_q),
        .b       (b_q),
        .in_ovf  (ovf_q | b_ovf_q),
        .prod_lo (mul_lo),
        .ovf_out (mul_ovf)
    );

    // b * b: next power-of-two power of the base.
    exponent_mul_step #(.WIDTH(WIDTH)) u_sq (
        .a       (b_q),
        .b       (b_q),
        .in_ovf  (b_ovf_q),
        .prod_lo (sq_lo),
        .ovf_out (sq_ovf)
    );

    // Next accumulator/overflow for this bit, termination test, and saturation of the final value.
    always_comb begin
        acc_d    = e_q[0] ? mul_lo  : acc_q;
        ovf_d    = e_q[0] ? mul_ovf : ovf_q;
        e_d      = e_q >> 1;
        last_bit = (e_d == '0);
        result_d = (SATURATE && ovf_d) ? '1 : acc_d;
    end

    // Controller, datapath registers and registered handshake outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            b_q        <= '0;
            acc_q      <= '0;
            e_q        <= '0;
            b_ovf_q    <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        b_q     <= bus.base;
                        e_q     <= bus.exponent;
                        acc_q   <= WIDTH'(1);
                        b_ovf_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    ovf_q   <= ovf_d;
                    b_q     <= sq_lo;
                    b_ovf_q <= sq_ovf;
                    e_q     <= e_d;
                    // Leave as soon as no set bits remain; result is taken from this cycle's update.
                    if (last_bit) begin
                        result_q   <= result_d;
                        overflow_q <= ovf_d;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule : exponent_unit

// File: tb/tb_exponent_unit.sv
// Self-checking bench: a wrapping and a saturating engine driven with identical requests.
module tb_exponent_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Results captured by do_op for the calling test.
    int          lat, busy_cnt;
    bit          timed_out;
    logic [31:0] res_w, res_s;
    logic        ovf_w, ovf_s, done_s, done_after, busy_after;

    always #5 clk = ~clk;

    exponent_unit_if #(.WIDTH(32), .EXP_WIDTH(8)) if_w ();
    exponent_unit_if #(.WIDTH(32), .EXP_WIDTH(8)) if_s ();

    exponent_unit #(.WIDTH(32), .EXP_WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (if_w.slave)
    );

    exponent_unit #(.WIDTH(32), .EXP_WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (if_s.slave)
    );

    // Reference: repeated multiplication, with the exact value tracked (capped) to detect >= 2^32.
    function automatic void ref_pow(input logic [31:0] b, input logic [7:0] e, input bit sat,
                                    output logic [31:0] r, output bit o);
        logic [31:0] w;
        logic [63:0] full;
        w    = 32'd1;
        full = 64'd1;
        o    = 1'b0;
        for (int i = 0; i < int'(e); i++) begin
            w    = w * b;
            full = full * {32'd0, b};
            if (full > 64'hFFFF_FFFF) begin
                o    = 1'b1;
                full = 64'h1_0000_0000;
            end
        end
        r = (sat && o) ? 32'hFFFF_FFFF : w;
    endfunction

    // Expected RUN cycles: bit length of the exponent, at least one.
    function automatic int ref_cycles(input logic [7:0] e);
        int m = 1;
        for (int i = 0; i < 8; i++) if (e[i]) m = i + 1;
        return m;
    endfunction

    task automatic set_inputs(input logic s, input logic [31:0] b, input logic [7:0] e);
        if_w.start = s; if_w.base = b; if_w.exponent = e;
        if_s.start = s; if_s.base = b; if_s.exponent = e;
    endtask

    // Issue one request; optionally keep hammering start with junk operands while busy.
    task automatic do_op(input logic [31:0] b, input logic [7:0] e, input bit poke);
        @(negedge clk);
        set_inputs(1'b1, b, e);
        @(posedge clk); #1;
        set_inputs(poke, $urandom, 8'($urandom));
        lat = 0;
        busy_cnt = if_w.busy ? 1 : 0;
        while (!if_w.done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (if_w.busy) busy_cnt++;
            if (poke && !if_w.done) set_inputs(1'b1, $urandom, 8'($urandom));
        end
        timed_out = !if_w.done;
        if (timed_out) begin
            n_checks++; n_fail++;
            $display("FAIL timeout %0d^%0d: no done within %0d cycles", b, e, lat);
        end
        res_w = if_w.result; ovf_w = if_w.overflow;
        res_s = if_s.result; ovf_s = if_s.overflow; done_s = if_s.done;
        @(posedge clk); #1;
        set_inputs(1'b0, $urandom, 8'($urandom));
        done_after = if_w.done;
        busy_after = if_w.busy;
        $display("op %0d^%0d -> wrap=%08h ovf=%0b sat=%08h ovf=%0b cycles=%0d",
                 b, e, res_w, ovf_w, res_s, ovf_s, lat);
    endtask

    task automatic test_reset();
        set_inputs(1'b0, 32'd0, 8'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({if_w.busy, if_w.done, if_w.result, if_w.overflow} !== 35'd0) begin
            n_fail++; $display("FAIL reset_wrap: got busy=%0b done=%0b result=%0h ovf=%0b, want all 0",
                               if_w.busy, if_w.done, if_w.result, if_w.overflow);
        end
        n_checks++;
        if ({if_s.busy, if_s.done, if_s.result, if_s.overflow} !== 35'd0) begin
            n_fail++; $display("FAIL reset_sat: got busy=%0b done=%0b result=%0h ovf=%0b, want all 0",
                               if_s.busy, if_s.done, if_s.result, if_s.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_op(32'd3, 8'd5, 1'b0);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
        n_checks++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", busy_cnt); end
        n_checks++; if (res_w !== 32'd243) begin n_fail++; $display("FAIL basic_result: got %0d want 243", res_w); end
        n_checks++; if (ovf_w !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %0b want 0", ovf_w); end
        n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: done still %0b after one cycle", done_after); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %0b want 0", busy_after); end
    endtask

    task automatic test_zero_exp();
        logic [31:0] bases [2] = '{32'd7, 32'd0};
        foreach (bases[i]) begin
            do_op(bases[i], 8'd0, 1'b0);
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_exp_latency base=%0d: got %0d want 1", bases[i], lat); end
            n_checks++; if ({res_w, ovf_w} !== {32'd1, 1'b0}) begin
                n_fail++; $display("FAIL zero_exp base=%0d: got %0d/%0b want 1/0", bases[i], res_w, ovf_w);
            end
        end
    endtask

    // Directed operand pairs compared against the model for both engines.
    task automatic test_boundaries();
        logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd65536, 32'd65536};
        logic [7:0]  es [4] = '{8'd31, 8'd32, 8'd1, 8'd2};
        logic [31:0] er_w, er_s;
        bit          eo_w, eo_s;
        foreach (bs[i]) begin
            ref_pow(bs[i], es[i], 1'b0, er_w, eo_w);
            ref_pow(bs[i], es[i], 1'b1, er_s, eo_s);
            do_op(bs[i], es[i], 1'b0);
            n_checks++; if ({res_w, ovf_w} !== {er_w, eo_w}) begin
                n_fail++; $display("FAIL boundary_wrap %0d^%0d: got %08h/%0b want %08h/%0b", bs[i], es[i], res_w, ovf_w, er_w, eo_w);
            end
            n_checks++; if ({res_s, ovf_s} !== {er_s, eo_s}) begin
                n_fail++; $display("FAIL boundary_sat %0d^%0d: got %08h/%0b want %08h/%0b", bs[i], es[i], res_s, ovf_s, er_s, eo_s);
            end
            n_checks++; if (lat !== ref_cycles(es[i])) begin
                n_fail++; $display("FAIL boundary_latency %0d^%0d: got %0d want %0d", bs[i], es[i], lat, ref_cycles(es[i]));
            end
        end
    endtask

    task automatic test_ignore_start();
        do_op(32'd3, 8'd5, 1'b1);
        n_checks++; if ({res_w, ovf_w} !== {32'd243, 1'b0}) begin
            n_fail++; $display("FAIL ignore_start_result: got %0d/%0b want 243/0", res_w, ovf_w);
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ignore_start_latency: got %0d want 3", lat); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({if_w.busy, if_w.result} !== {1'b0, 32'd243}) begin
            n_fail++; $display("FAIL ignore_start_idle: got busy=%0b result=%0d want 0/243", if_w.busy, if_w.result);
        end
        do_op(32'd2, 8'd10, 1'b0);
        n_checks++; if (res_w !== 32'd1024) begin n_fail++; $display("FAIL ignore_start_next: got %0d want 1024", res_w); end
    endtask

    task automatic test_random();
        logic [31:0] b, er_w, er_s;
        logic [7:0]  e;
        bit          eo_w, eo_s;
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 5);
                1: b = 32'd1 << $urandom_range(0, 31);
                2: b = $urandom;
                default: b = $urandom_range(0, 300);
            endcase
            e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
            ref_pow(b, e, 1'b0, er_w, eo_w);
            ref_pow(b, e, 1'b1, er_s, eo_s);
            do_op(b, e, $urandom_range(0, 1) == 1);
            n_checks++; if ({res_w, ovf_w} !== {er_w, eo_w}) begin
                n_fail++; $display("FAIL random_wrap %0d^%0d: got %08h/%0b want %08h/%0b", b, e, res_w, ovf_w, er_w, eo_w);
            end
            n_checks++; if ({res_s, ovf_s, done_s} !== {er_s, eo_s, 1'b1}) begin
                n_fail++; $display("FAIL random_sat %0d^%0d: got %08h/%0b done=%0b want %08h/%0b done=1", b, e, res_s, ovf_s, done_s, er_s, eo_s);
            end
            n_checks++; if (lat !== ref_cycles(e)) begin
                n_fail++; $display("FAIL random_latency %0d^%0d: got %0d want %0d", b, e, lat, ref_cycles(e));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        set_inputs(1'b1, 32'd3, 8'd200);
        @(posedge clk); #1;
        set_inputs(1'b0, 32'd0, 8'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if_w.busy, if_w.done, if_w.result, if_w.overflow} !== 35'd0) begin
            n_fail++; $display("FAIL reset_mid_run: got busy=%0b done=%0b result=%0h ovf=%0b, want all 0",
                               if_w.busy, if_w.done, if_w.result, if_w.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (if_w.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %0b want 0", if_w.busy); end
        do_op(32'd3, 8'd4, 1'b0);
        n_checks++; if ({res_w, ovf_w} !== {32'd81, 1'b0}) begin
            n_fail++; $display("FAIL reset_fresh_op: got %0d/%0b want 81/0", res_w, ovf_w);
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL reset_fresh_latency: got %0d want 3", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_exp();
        test_boundaries();
        test_ignore_start();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_exponent_unit
